// File: rtl/vga_pkg.sv
// Shared types for the VGA test-pattern path: scheduler states and pattern index.
package vga_pkg;

  localparam int unsigned NUM_PAT_DEF = 8;
  localparam int unsigned PAT_W_DEF   = 4;
  localparam int unsigned CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } sched_state_e;

  typedef logic [PAT_W_DEF-1:0] pat_idx_t;

endpackage

// File: rtl/vga_pattern_sched.sv
// Frame-synchronous test-pattern scheduler: auto-advance plus manual next/prev/pause,
// with every pattern change landing on a frame boundary.
module vga_pattern_sched
  import vga_pkg::*;
#(
  parameter int unsigned NUM_PAT = NUM_PAT_DEF,
  parameter int unsigned PAT_W   = PAT_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  input  logic             frame_start,
  input  logic [CNT_W-1:0] hold_frames,
  input  logic             next_req,
  input  logic             prev_req,
  input  logic             pause_req,
  output logic [PAT_W-1:0] pat_sel,
  output logic             paused,
  output logic             switch_pulse,
  output logic [CNT_W-1:0] frame_cnt
);

  sched_state_e     state, state_n;
  logic             nxt_pend, prv_pend, pse_pend;
  logic             nxt_n, prv_n, pse_n;
  logic [PAT_W-1:0] pat_n, pat_inc, pat_dec;
  logic [CNT_W-1:0] cnt_n, hold_m1;
  logic             step;

  assign pat_inc = (pat_sel == PAT_W'(NUM_PAT - 1)) ? '0 : pat_sel + PAT_W'(1);
  assign pat_dec = (pat_sel == '0) ? PAT_W'(NUM_PAT - 1) : pat_sel - PAT_W'(1);
  assign hold_m1 = hold_frames - CNT_W'(1);
  assign step    = nxt_pend | prv_pend;

  // State, pattern, counter and request-latch registers
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      pat_sel      <= '0;
      frame_cnt    <= '0;
      paused       <= 1'b0;
      switch_pulse <= 1'b0;
      nxt_pend     <= 1'b0;
      prv_pend     <= 1'b0;
      pse_pend     <= 1'b0;
    end else begin
      state        <= state_n;
      pat_sel      <= pat_n;
      frame_cnt    <= cnt_n;
      paused       <= (state_n == PAUSED);
      switch_pulse <= frame_start && (pat_n != pat_sel);
      nxt_pend     <= nxt_n;
      prv_pend     <= prv_n;
      pse_pend     <= pse_n;
    end
  end

  // Frame-boundary actions use the flags latched before this cycle; new requests
  // arriving now are folded in afterwards so they wait for the next frame_start.
  always_comb begin
    state_n = state;
    pat_n   = pat_sel;
    cnt_n   = frame_cnt;
    nxt_n   = nxt_pend;
    prv_n   = prv_pend;
    pse_n   = pse_pend;

    if (frame_start) begin
      if (nxt_pend)      pat_n = pat_inc;
      else if (prv_pend) pat_n = pat_dec;

      unique case (state)
        IDLE: begin
          state_n = RUN;
          cnt_n   = '0;
        end
        RUN: begin
          if (step) begin
            cnt_n = '0;
          end else if (!pse_pend) begin
            if (hold_frames == '0) begin
              if (frame_cnt != '1) cnt_n = frame_cnt + CNT_W'(1);
            end else if (frame_cnt >= hold_m1) begin
              pat_n = pat_inc;
              cnt_n = '0;
            end else begin
              cnt_n = frame_cnt + CNT_W'(1);
            end
          end
          if (pse_pend) state_n = PAUSED;
        end
        PAUSED: begin
          if (step || pse_pend) cnt_n = '0;
          if (pse_pend) state_n = RUN;
        end
        default: state_n = IDLE;
      endcase

      nxt_n = 1'b0;
      prv_n = 1'b0;
      // A pause request seen while IDLE is kept for the first running frame
      if (state != IDLE) pse_n = 1'b0;
    end

    if (next_req && prev_req) begin
      nxt_n = 1'b0;
      prv_n = 1'b0;
    end else if (next_req) begin
      nxt_n = 1'b1;
      prv_n = 1'b0;
    end else if (prev_req) begin
      prv_n = 1'b1;
      nxt_n = 1'b0;
    end
    if (pause_req) pse_n = ~pse_n;
  end

endmodule
